// File: rtl/led_bar_pwm_pkg.sv
// mcu_led_pkg: shared widths and types for the LED-bar PWM slice.
package mcu_led_pkg;
  localparam int DUTY_W_DEF = 4;
  localparam int CHANNELS_DEF = 8;
  localparam int PWM_MAX = 2**DUTY_W_DEF - 2;
  typedef logic [DUTY_W_DEF-1:0] duty_t;
endpackage

// File: rtl/led_bar_pwm_if.sv
// led_bar_pwm_if: brightness word, enable and LED/period/duty outputs of the PWM block.
interface led_bar_pwm_if
  import mcu_led_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DUTY_W = DUTY_W_DEF
);
  logic [CHANNELS*DUTY_W-1:0] data_i;
  logic en_i;
  logic [CHANNELS-1:0] led_o;
  logic period_o;
  logic [CHANNELS*DUTY_W-1:0] duty_o;
  modport master (output data_i, en_i, input led_o, period_o, duty_o);
  modport slave (input data_i, en_i, output led_o, period_o, duty_o);
endinterface

// File: rtl/led_bar_pwm_chan.sv
// led_bar_pwm_chan: one channel's shadow brightness and registered PWM compare.
// LED_BAR_PWM_FADE_EN makes the shadow step by one code per period toward its target.
module led_bar_pwm_chan #(
  parameter int DUTY_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              en,
  input  logic              pe,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic [DUTY_W-1:0] data,
  output logic              led,
  output logic [DUTY_W-1:0] duty
);
  logic [DUTY_W-1:0] shadow, shadow_nxt;
  always_comb begin
`ifdef LED_BAR_PWM_FADE_EN
    shadow_nxt = !en ? data : !pe ? shadow :
                 shadow < data ? shadow + 1'b1 : shadow > data ? shadow - 1'b1 : shadow;
`else
    shadow_nxt = (!en || pe) ? data : shadow;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      shadow <= '0;
      led <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      led <= en && (pwm_cnt < shadow);
    end
  end
  assign duty = shadow;
endmodule

// File: rtl/led_bar_pwm.sv
// led_bar_pwm: prescaled PWM driver for the LED bar, shadow loaded at period ends.
// Optional LED_BAR_PWM_FADE_EN: brightness fades one code per period instead of jumping.
module led_bar_pwm
  import mcu_led_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int PRESC = 16
) (
  input logic clk_i,
  input logic rst_in,
  led_bar_pwm_if.slave bus
);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(2**DUTY_W - 2);
  logic [PW-1:0] presc_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic tick, pe, period;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS*DUTY_W-1:0] duty;
  assign tick = bus.en_i && presc_cnt == PRESC_LAST;
  assign pe = tick && pwm_cnt == CNT_LAST;
  // counters sit at zero while disabled so re-enable starts a fresh period
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      presc_cnt <= '0;
      pwm_cnt <= '0;
      period <= 1'b0;
    end else begin
      presc_cnt <= (!bus.en_i || tick) ? '0 : presc_cnt + 1'b1;
      pwm_cnt <= (!bus.en_i || pe) ? '0 : tick ? pwm_cnt + 1'b1 : pwm_cnt;
      period <= pe;
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_bar_pwm_chan #(.DUTY_W(DUTY_W)) u_chan (
      .clk_i   (clk_i),
      .rst_in  (rst_in),
      .en      (bus.en_i),
      .pe      (pe),
      .pwm_cnt (pwm_cnt),
      .data    (bus.data_i[i*DUTY_W +: DUTY_W]),
      .led     (led[i]),
      .duty    (duty[i*DUTY_W +: DUTY_W])
    );
  end
  assign bus.led_o = led;
  assign bus.period_o = period;
  assign bus.duty_o = duty;
endmodule

// File: tb/tb_led_bar_pwm.sv
// tb_led_bar_pwm: randomized and directed checks of led_bar_pwm against a period-level model.
module tb_led_bar_pwm;
  import mcu_led_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  led_bar_pwm_if #(.CHANNELS(8), .DUTY_W(4)) b1 ();
  led_bar_pwm_if #(.CHANNELS(8), .DUTY_W(4)) b2 ();
  led_bar_pwm #(.PRESC(1)) u1 (.clk_i(clk), .rst_in(rst_n), .bus(b1.slave));
  led_bar_pwm #(.PRESC(256)) u2 (.clk_i(clk), .rst_in(rst_n), .bus(b2.slave));
  int checks = 0;
  int errors = 0;
  logic [31:0] cur;
  logic [7:0] led_exp;
  logic per_exp;
  int n, cyc_no, p2_first, p2_second;
  int hi [8];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] load(input logic [31:0] c, input logic [31:0] d);
`ifdef LED_BAR_PWM_FADE_EN
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      int a, t;
      a = int'(c[i*4 +: 4]);
      t = int'(d[i*4 +: 4]);
      r[i*4 +: 4] = 4'(a < t ? a + 1 : a > t ? a - 1 : a);
    end
    return r;
`else
    return c ^ c ^ d;
`endif
  endfunction
  // one clock: model the edge from the rules, then compare at the falling edge
  task automatic cyc();
    int pos;
    @(posedge clk);
    if (b1.en_i) begin
      n++;
      pos = (n - 1) % 15;
      for (int i = 0; i < 8; i++) led_exp[i] = int'(cur[i*4 +: 4]) > pos;
      per_exp = (n % 15 == 0);
      if (per_exp) cur = load(cur, b1.data_i);
    end else begin
      n = 0;
      led_exp = '0;
      per_exp = 1'b0;
      cur = b1.data_i;
    end
    @(negedge clk);
    cyc_no++;
    chk("led", 32'(b1.led_o), 32'(led_exp));
    chk("period", 32'(b1.period_o), 32'(per_exp));
    chk("duty", b1.duty_o, cur);
    for (int i = 0; i < 8; i++) hi[i] += int'(b1.led_o[i]);
    if (b2.period_o === 1'b1) begin
      if (p2_first < 0) p2_first = cyc_no;
      else if (p2_second < 0) p2_second = cyc_no;
    end
  endtask
  // one aligned period; optionally change data after k cycles; checks lit counts
  task automatic period_hi(input int k, input logic [31:0] v);
    logic [31:0] snap;
    duty_t f;
    snap = cur;
    for (int i = 0; i < 8; i++) hi[i] = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == k) b1.data_i = v;
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      f = snap[i*4 +: 4];
      chk($sformatf("hi_ch%0d", i), 32'(hi[i]), 32'(f));
    end
  endtask
  initial begin
    p2_first = -1;
    p2_second = -1;
    cyc_no = 0;
    b1.en_i = 1'b1;
    b1.data_i = 32'hFFFF_FFFF;
    b2.en_i = 1'b1;
    b2.data_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(b1.led_o), 32'h0);
    chk("rst_period", 32'(b1.period_o), 32'h0);
    chk("rst_duty", b1.duty_o, 32'h0);
    chk("rst_led_p256", 32'(b2.led_o), 32'h0);
    chk("rst_duty_p256", b2.duty_o, 32'h0);
    rst_n = 1'b1;
    cur = '0;
    n = 0;
    b1.data_i = 32'hF840_1000;
    period_hi(-1, 0);
    b1.data_i = 32'h0000_0007;
    period_hi(-1, 0);
    period_hi(-1, 0);
    period_hi(7, 32'h0000_0003);
    period_hi(-1, 0);
    repeat (6) cyc();
    b1.en_i = 1'b0;
    repeat (3) cyc();
    b1.data_i = 32'h0000_0005;
    cyc();
    b1.en_i = 1'b1;
    period_hi(-1, 0);
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 9) == 0) b1.data_i = $urandom;
      if (b1.en_i ? $urandom_range(0, 199) == 0 : $urandom_range(0, 2) == 0) b1.en_i = ~b1.en_i;
      cyc();
    end
    chk("p256_first", 32'(p2_first), 32'd3840);
    chk("p256_interval", 32'(p2_second - p2_first), 32'd3840);
`ifdef LED_BAR_PWM_FADE_EN
    b1.en_i = 1'b0;
    b1.data_i = 32'h0;
    cyc();
    b1.en_i = 1'b1;
    b1.data_i = 32'h3;
    for (int s = 1; s <= 4; s++) begin
      repeat (15) cyc();
      chk($sformatf("fade_up%0d", s), 32'(b1.duty_o[3:0]), 32'(s > 3 ? 3 : s));
    end
    b1.data_i = 32'h0;
    for (int s = 1; s <= 4; s++) begin
      repeat (15) cyc();
      chk($sformatf("fade_dn%0d", s), 32'(b1.duty_o[3:0]), 32'(s > 3 ? 0 : 3 - s));
    end
`endif
    b1.en_i = 1'b0;
    b1.data_i = 32'h0000_000F;
    cyc();
    b1.en_i = 1'b1;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("async_led", 32'(b1.led_o), 32'h0);
    chk("async_duty", b1.duty_o, 32'h0);
    chk("async_period", 32'(b1.period_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = '0;
    n = 0;
    period_hi(-1, 0);
    period_hi(-1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
